// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter datapath.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } ser_state_t;

    localparam int   UART_DEFAULT_DATA_WIDTH = 8;
    localparam logic LINE_IDLE               = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Parallel-to-serial shifter for the UART TX datapath: one bit per clock, ser_done on the last bit.
// Build option UART_SER_MSB_FIRST_EN selects MSB-first order; LSB-first otherwise.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_done
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    ser_state_t            state_r;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  ser_data_r;
    logic                  ser_done_r;

    logic                  first_bit_s;
    logic                  next_bit_s;
    logic [DATA_WIDTH-1:0] shreg_rot_s;

    // The register rotates rather than shifts; the stale bit wraps around and is never presented.
`ifdef UART_SER_MSB_FIRST_EN
    assign first_bit_s = p_data[DATA_WIDTH-1];
    assign next_bit_s  = shreg_r[DATA_WIDTH-2];
    assign shreg_rot_s = {shreg_r[DATA_WIDTH-2:0], shreg_r[DATA_WIDTH-1]};
`else
    assign first_bit_s = p_data[0];
    assign next_bit_s  = shreg_r[1];
    assign shreg_rot_s = {shreg_r[0], shreg_r[DATA_WIDTH-1:1]};
`endif

    // Frame FSM with counter, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            shreg_r    <= {DATA_WIDTH{1'b0}};
            ser_data_r <= LINE_IDLE;
            ser_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ser_en) begin
                        state_r    <= ST_SHIFT;
                        cnt_r      <= {CNT_W{1'b0}};
                        shreg_r    <= p_data;
                        ser_data_r <= first_bit_s;
                        ser_done_r <= 1'b0;
                    end else begin
                        ser_data_r <= LINE_IDLE;
                        ser_done_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == LAST_CNT) begin
                        state_r    <= ser_en ? ST_HOLD : ST_IDLE;
                        ser_data_r <= LINE_IDLE;
                        ser_done_r <= 1'b0;
                    end else if (!ser_en) begin
                        // Abort: the partial word is dropped and ser_done never fires.
                        state_r    <= ST_IDLE;
                        ser_data_r <= LINE_IDLE;
                        ser_done_r <= 1'b0;
                    end else begin
                        cnt_r      <= cnt_r + CNT_W'(1);
                        shreg_r    <= shreg_rot_s;
                        ser_data_r <= next_bit_s;
                        ser_done_r <= ((cnt_r + CNT_W'(1)) == LAST_CNT);
                    end
                end
                ST_HOLD: begin
                    state_r    <= ser_en ? ST_HOLD : ST_IDLE;
                    ser_data_r <= LINE_IDLE;
                    ser_done_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ser_data_r <= LINE_IDLE;
                    ser_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign ser_data = ser_data_r;
    assign ser_done = ser_done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       ser_en;
    logic       ser_data;
    logic       ser_done;

    typedef struct packed {
        logic exp_data;
        logic exp_done;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   n_checks;
    int   n_fails;
    int   step_no;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .p_data  (p_data),
        .ser_en  (ser_en),
        .ser_data(ser_data),
        .ser_done(ser_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle once an expectation exists for it.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_checks++;
            if (ser_data !== e.exp_data || ser_done !== e.exp_done) begin
                n_fails++;
                $display("FAIL step%0d ser_data/ser_done: got %b/%b expected %b/%b",
                         t, ser_data, ser_done, e.exp_data, e.exp_done);
            end
        end
    end

    // One clock edge with given inputs; expectation is for the outputs after that edge.
    task automatic step(input logic r, input logic en, input logic [7:0] d,
                        input logic ed, input logic edn);
        exp_t e;
        rst    = r;
        ser_en = en;
        p_data = d;
        @(posedge clk);
        #1;
        e.exp_data = ed;
        e.exp_done = edn;
        exp_q.push_back(e);
        tag_q.push_back(step_no);
        step_no++;
    endtask

    // n edges with ser_en high; stream lists the expected bits first-bit-leftmost.
    // p_data switches to d2 from edge index chg onward.
    task automatic run_bits(input logic [7:0] d, input logic [7:0] d2, input int chg,
                            input logic [7:0] stream, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1, (k >= chg) ? d2 : d, stream[7-k], (k == 7) ? 1'b1 : 1'b0);
        end
    endtask

`ifdef UART_SER_MSB_FIRST_EN
    localparam logic [7:0] S_B9 = 8'b10111001;
    localparam logic [7:0] S_89 = 8'b10001001;
    localparam logic [7:0] S_CA = 8'b11000000;
`else
    localparam logic [7:0] S_B9 = 8'b10011101;
    localparam logic [7:0] S_89 = 8'b10010001;
    localparam logic [7:0] S_CA = 8'b01010000;
`endif
    localparam logic [7:0] S_66 = 8'b01100110;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        step_no  = 0;
        rst      = 1'b1;
        ser_en   = 1'b0;
        p_data   = 8'h00;

        // Reset with enable low.
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Full frame, enable held 10 edges: HOLD must not restart.
        run_bits(8'b10111001, 8'b10111001, 99, S_B9, 8);
        step(1'b0, 1'b1, 8'b10111001, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'b10111001, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'b10111001, 1'b1, 1'b0);

        // p_data changes three cycles after load: stream unchanged.
        run_bits(8'b10111001, 8'b10110101, 3, S_B9, 8);
        step(1'b0, 1'b0, 8'b10110101, 1'b1, 1'b0);

        // Back-to-back after a one-cycle gap.
        run_bits(8'b10001001, 8'b10001001, 99, S_89, 8);
        step(1'b0, 1'b0, 8'b10001001, 1'b1, 1'b0);

        // Abort after 4 bits, then fresh reload.
        run_bits(8'b11001010, 8'b11001010, 99, S_CA, 4);
        step(1'b0, 1'b0, 8'b11001010, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'b11001010, 1'b1, 1'b0);
        run_bits(8'b01100110, 8'b01100110, 99, S_66, 8);
        step(1'b0, 1'b0, 8'b01100110, 1'b1, 1'b0);

        // Mid-frame reset with enable high, reset priority in IDLE.
        run_bits(8'h00, 8'h00, 99, 8'h00, 3);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'b10111001, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'b10111001, 1'b1, 1'b0);

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parallel-to-serial shifter of the UART transmitter datapath. When the TX controller FSM asserts `ser_en`, the block captures a data word and shifts it out one bit per clock on `ser_data`. It flags the final bit with `ser_done` so the controller can advance to the parity or stop stage. The block sits between the TX controller and the output bit mux.

## Interface
- `DATA_WIDTH`, default 8: width of the parallel word; must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `p_data`  in  DATA_WIDTH  parallel word; sampled only on the load edge.
- `ser_en`  in  1  level enable from the TX controller; held high for the whole frame.
- `ser_data`  out  1  serial bit, registered.
- `ser_done`  out  1  high while the last data bit is on `ser_data`, registered.

## Operation
- Three states:
  - IDLE: waiting for `ser_en`.
  - SHIFT: word in progress.
  - HOLD: word finished, `ser_en` still high.
- IDLE → SHIFT on an edge where `ser_en`=1:
  - shift register ← `p_data`
  - bit counter ← 0
- SHIFT:
  - each edge advances the counter and shifts by one;
  - `ser_data` presents bit 0 first (LSB-first by default).
- SHIFT → HOLD at the edge after the last bit if `ser_en`=1.
- SHIFT → IDLE at that edge if `ser_en`=0.
- HOLD → IDLE when `ser_en`=0.
  - A new load always requires `ser_en` to be low for at least one edge, so a held enable never restarts a frame.
- Abort: `ser_en`=0 sampled in SHIFT before the final bit → IDLE at that edge. `ser_data`=1 and `ser_done`=0; the word is discarded.
- Changes to `p_data` after the load edge have no effect on the current word.
- In IDLE and HOLD:
  - `ser_data`=1 (line-idle level);
  - `ser_done`=0.
- Counter width is $clog2(DATA_WIDTH). It never wraps, because the exit occurs at count DATA_WIDTH-1.

## Timing
- Reset (`rst`=1 at an edge), including mid-frame:
  - state=IDLE, counter=0, shift register=0;
  - `ser_data`=1, `ser_done`=0.
  - Reset has priority over `ser_en`.
- Load edge E0 (ser_en sampled 1 in IDLE): after E0, `ser_data`=bit 0. Latency from enable to first bit is one cycle.
- After edge E0+k (k=0..DATA_WIDTH-1), `ser_data`=bit k.
- `ser_done`=1 exactly during the cycle after E0+DATA_WIDTH-1, coincident with the last bit. It is a one-cycle pulse per completed word.
- At E0+DATA_WIDTH: `ser_data` returns to 1, `ser_done` to 0, and the state becomes HOLD or IDLE.
- An aborted frame never pulses `ser_done`.
- Back-to-back frames: with a one-cycle `ser_en` low gap, the next load edge can be E0+DATA_WIDTH+1.

## Configuration
- `UART_SER_MSB_FIRST_EN`:
  - Defined: the word is shifted MSB-first; bit DATA_WIDTH-1 appears first.
  - Undefined (default): LSB-first, as UART requires.
- Timing and `ser_done` placement are identical in both builds.

## Structure
- Shared package `uart_tx_pkg`:
  - state enum typedef (IDLE/SHIFT/HOLD);
  - default `DATA_WIDTH` constant;
  - the idle-line level constant (1'b1).
- No sub-module: the counter and shift register are small enough to stay inline in `uart_tx_serializer`.

## Test plan
- Reset with `ser_en`=0 → `ser_data`=1, `ser_done`=0; assert synchronous reset mid-frame → both return to those values at the next edge.
- Load `p_data`=8'b10111001 with `ser_en` held 10 cycles → `ser_data` = 1,0,0,1,1,1,0,1 on consecutive cycles. `ser_done`=1 only with the eighth bit, then `ser_data`=1 with no restart while `ser_en` stays high.
- Same frame with `p_data` changed to 8'b10110101 three cycles after load → output stream unchanged (1,0,0,1,1,1,0,1).
- Drop `ser_en` for one cycle, then load 8'b10001001 → 1,0,0,1,0,0,0,1 with a single `ser_done` pulse on the last bit.
- Deassert `ser_en` after 4 bits → `ser_data`=1 next cycle, no `ser_done`; the next enable reloads fresh `p_data`.
- With `UART_SER_MSB_FIRST_EN` defined, 8'b10111001 → 1,0,1,1,1,0,0,1; `ser_done` timing is identical.
